// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared definitions for the cache miss controller.
//   - state_t         : controller FSM encoding
//   - OFFSET_W/INDEX_W: byte-offset and set-index widths of the 2-way, 8-set, 32-byte-line cache
//   - LINE_ALIGN_MASK : clears the byte offset to form a line address (truncate to ADDR_W)
package cache_ctrl_pkg;

    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned INDEX_W  = 3;

    localparam logic [63:0] LINE_ALIGN_MASK = ~((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MISS_REQ = 3'd2,
        FILL     = 3'd3,
        REPLAY   = 3'd4,
        WT_REQ   = 3'd5
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; cleared only by reset.
//   clk   : clock
//   reset : asynchronous active-high reset
//   inc   : count enable for this cycle
//   count : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Saturating increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_miss_controller.sv
// cache_miss_controller: sequences a byte cache for one CPU requester.
// Read misses fetch a line from memory, fill the cache and replay the lookup;
// all writes go through to memory, write hits also update the cached byte.
//   CPU side   : cpu_req/cpu_we/cpu_addr/cpu_wdata in; cpu_stall/cpu_done/cpu_rdata/cpu_err out
//   Cache side : cache_addr, cache_byte_we, cache_wbyte, cache_fill, cache_fill_line out;
//                cache_hit, cache_data in (combinational for cache_addr)
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata out; mem_ready/mem_rdata in
//   Statistics : hit_cnt, miss_cnt (saturating)
module cache_miss_controller
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [7:0]        cache_data,
    output logic              cache_byte_we,
    output logic [7:0]        cache_wbyte,
    output logic              cache_fill,
    output logic [LINE_W-1:0] cache_fill_line,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TMO_EN = (TIMEOUT != 0);

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic [LINE_W-1:0]   r_line;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_done;
    logic                r_err;
    logic                r_stall;
    logic [7:0]          r_rdata;

    logic                w_accept;
    logic                w_rdata_ld;
    logic                w_line_ld;
    logic                w_done_d;
    logic                w_err_d;
    logic                w_wait_clr;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_expire;
    logic                w_mem_busy;

    // Expiry is decided in the cycle the wait count would reach TIMEOUT; a
    // mem_ready in that same cycle still completes the transfer.
    assign w_expire   = TMO_EN && !mem_ready && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_mem_busy = (r_state == MISS_REQ) || (r_state == WT_REQ);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_rdata_ld = 1'b0;
        w_line_ld  = 1'b0;
        w_done_d   = 1'b0;
        w_err_d    = 1'b0;
        w_wait_clr = 1'b0;
        w_hit_inc  = 1'b0;
        w_miss_inc = 1'b0;

        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_accept = 1'b1;
                    w_next   = LOOKUP;
                end
            end
            LOOKUP: begin
                // Every exit to a memory state passes through here
                w_wait_clr = 1'b1;
                if (cache_hit) begin
                    w_hit_inc = 1'b1;
                    if (r_we) begin
                        w_next = WT_REQ;
                    end else begin
                        w_rdata_ld = 1'b1;
                        w_done_d   = 1'b1;
                        w_next     = IDLE;
                    end
                end else begin
                    w_miss_inc = 1'b1;
                    w_next     = r_we ? WT_REQ : MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_ready) begin
                    w_line_ld = 1'b1;
                    w_next    = FILL;
                end else if (w_expire) begin
                    w_done_d = 1'b1;
                    w_err_d  = 1'b1;
                    w_next   = IDLE;
                end
            end
            FILL: begin
                w_next = REPLAY;
            end
            REPLAY: begin
                w_done_d = 1'b1;
                if (cache_hit) begin
                    w_rdata_ld = 1'b1;
                end else begin
                    w_err_d = 1'b1;
                end
                w_next = IDLE;
            end
            WT_REQ: begin
                if (mem_ready) begin
                    w_done_d = 1'b1;
                    w_next   = IDLE;
                end else if (w_expire) begin
                    w_done_d = 1'b1;
                    w_err_d  = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latches, fill buffer, wait counter and registered CPU outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_line  <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (w_line_ld) begin
                r_line <= mem_rdata;
            end
            if (w_rdata_ld) begin
                r_rdata <= cache_data;
            end
            r_done <= w_done_d;
            r_err  <= w_err_d;
            // Stall drops the cycle after done unless a new request is taken then
            if (w_accept) begin
                r_stall <= 1'b1;
            end else if (r_done) begin
                r_stall <= 1'b0;
            end
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if (w_mem_busy && !mem_ready && (r_wait != {WAIT_W{1'b1}})) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_miss_inc),
        .count (miss_cnt)
    );

    // Cache and memory strobes decode from the state register only, so a
    // reset clears them without waiting for a clock edge.
    assign cache_addr      = (r_state == IDLE) ? cpu_addr : r_addr;
    assign cache_byte_we   = (r_state == LOOKUP) && r_we && cache_hit;
    assign cache_wbyte     = r_wdata;
    assign cache_fill      = (r_state == FILL);
    assign cache_fill_line = r_line;

    assign mem_req   = w_mem_busy;
    assign mem_we    = (r_state == WT_REQ);
    assign mem_addr  = (r_state == WT_REQ) ? r_addr : (r_addr & ADDR_W'(LINE_ALIGN_MASK));
    assign mem_wdata = r_wdata;

    assign cpu_stall = r_stall;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb_cache_miss_controller: directed bench for cache_miss_controller with a
// behavioural 2-way 8-set cache and a line memory whose byte i at aligned
// address A is A[7:0]+i. Memory latency is set per transaction via mem_lat
// (-1 = never ready).
module tb_cache_miss_controller;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_stall;
    logic              cpu_done;
    logic [7:0]        cpu_rdata;
    logic              cpu_err;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [7:0]        cache_data;
    logic              cache_byte_we;
    logic [7:0]        cache_wbyte;
    logic              cache_fill;
    logic [LINE_W-1:0] cache_fill_line;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    always #5 clk = ~clk;

    cache_miss_controller #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_stall      (cpu_stall),
        .cpu_done       (cpu_done),
        .cpu_rdata      (cpu_rdata),
        .cpu_err        (cpu_err),
        .cache_addr     (cache_addr),
        .cache_hit      (cache_hit),
        .cache_data     (cache_data),
        .cache_byte_we  (cache_byte_we),
        .cache_wbyte    (cache_wbyte),
        .cache_fill     (cache_fill),
        .cache_fill_line(cache_fill_line),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural cache: index = addr[7:5], tag = addr[31:8]
    logic [15:0]  m_valid = '0;
    logic [23:0]  m_tag  [16];
    logic [255:0] m_data [16];
    logic [2:0]   m_set;
    logic [23:0]  m_tagv;
    logic [4:0]   m_off;
    logic         m_hit;
    logic         m_way;
    logic         m_fill_way;

    assign m_set      = cache_addr[7:5];
    assign m_tagv     = cache_addr[31:8];
    assign m_off      = cache_addr[4:0];
    assign m_fill_way = m_valid[{m_set, 1'b0}];

    always_comb begin
        m_hit = 1'b0;
        m_way = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[{m_set, 1'(w)}] && (m_tag[{m_set, 1'(w)}] == m_tagv)) begin
                m_hit = 1'b1;
                m_way = 1'(w);
            end
        end
    end

    assign cache_hit  = m_hit;
    assign cache_data = m_data[{m_set, m_way}][{m_off, 3'b000} +: 8];

    always @(posedge clk) begin
        if (cache_fill) begin
            m_valid[{m_set, m_fill_way}] <= 1'b1;
            m_tag[{m_set, m_fill_way}]   <= m_tagv;
            m_data[{m_set, m_fill_way}]  <= cache_fill_line;
        end
        if (cache_byte_we && m_hit) begin
            m_data[{m_set, m_way}][{m_off, 3'b000} +: 8] <= cache_wbyte;
        end
    end

    // Memory responder
    int mem_lat = 0;
    int req_age = 0;

    always @(posedge clk) begin
        if (!mem_req || mem_ready) req_age <= 0;
        else                       req_age <= req_age + 1;
    end

    assign mem_ready = mem_req && (mem_lat >= 0) && (req_age == mem_lat);

    always_comb begin
        for (int i = 0; i < 32; i++) mem_rdata[i*8 +: 8] = mem_addr[7:0] + 8'(i);
    end

    // Event monitors
    int          n_fill = 0;
    int          n_bwe  = 0;
    int          n_mreq = 0;
    int          n_wr   = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;

    always @(posedge clk) begin
        if (cache_fill)    n_fill <= n_fill + 1;
        if (cache_byte_we) n_bwe  <= n_bwe + 1;
        if (mem_req)       n_mreq <= n_mreq + 1;
        if (mem_req && mem_ready && mem_we) begin
            n_wr    <= n_wr + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (mem_req && mem_ready && !mem_we) rd_addr <= mem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction: returns cycles from request to done, err/rdata at done
    task automatic xact(input logic we, input logic [31:0] a, input logic [7:0] wd,
                        output int lat, output logic err, output logic [7:0] rd);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        tick();
        cpu_req = 1'b0;
        chk("stall_on_accept", 32'(cpu_stall), 32'd1);
        lat = 1;
        while (!cpu_done && lat < 60) begin
            tick();
            lat++;
        end
        err = cpu_err;
        rd  = cpu_rdata;
        chk("stall_at_done", 32'(cpu_stall), 32'd1);
        tick();
        chk("stall_after_done", 32'(cpu_stall), 32'd0);
        chk("done_one_cycle", 32'(cpu_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        err;
        logic [7:0]  rd;
        int          f0, q0, b0, w0;

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Read miss; mem_ready arrives in the last allowed wait cycle
        mem_lat = 3;
        f0 = n_fill; q0 = n_mreq;
        xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
        chk("miss_latency", 32'(lat), 32'd8);
        chk("miss_rdata", 32'(rd), 32'h62);
        chk("miss_err", 32'(err), 32'd0);
        chk("miss_fill_pulses", 32'(n_fill - f0), 32'd1);
        chk("miss_mem_req_cycles", 32'(n_mreq - q0), 32'd4);
        chk("miss_mem_addr", rd_addr, 32'h00A0_0060);
        chk("miss_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("miss_hit_cnt", 32'(hit_cnt), 32'd0);

        // Same read now hits
        q0 = n_mreq;
        xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
        chk("hit_latency", 32'(lat), 32'd2);
        chk("hit_rdata", 32'(rd), 32'h62);
        chk("hit_no_mem_req", 32'(n_mreq - q0), 32'd0);
        chk("hit_hit_cnt", 32'(hit_cnt), 32'd1);

        // Write hit
        mem_lat = 1;
        b0 = n_bwe; w0 = n_wr; f0 = n_fill;
        xact(1'b1, 32'h00A0_0062, 8'hAA, lat, err, rd);
        chk("wrhit_latency", 32'(lat), 32'd4);
        chk("wrhit_byte_we", 32'(n_bwe - b0), 32'd1);
        chk("wrhit_mem_writes", 32'(n_wr - w0), 32'd1);
        chk("wrhit_mem_addr", wr_addr, 32'h00A0_0062);
        chk("wrhit_mem_wdata", 32'(wr_data), 32'hAA);
        chk("wrhit_no_fill", 32'(n_fill - f0), 32'd0);
        chk("wrhit_hit_cnt", 32'(hit_cnt), 32'd2);

        xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
        chk("rd_after_wr_latency", 32'(lat), 32'd2);
        chk("rd_after_wr_rdata", 32'(rd), 32'hAA);
        chk("rd_after_wr_hit_cnt", 32'(hit_cnt), 32'd3);

        // Write miss: memory only, no allocation
        b0 = n_bwe; w0 = n_wr; f0 = n_fill;
        xact(1'b1, 32'h1234_5678, 8'hBB, lat, err, rd);
        chk("wrmiss_latency", 32'(lat), 32'd4);
        chk("wrmiss_byte_we", 32'(n_bwe - b0), 32'd0);
        chk("wrmiss_no_fill", 32'(n_fill - f0), 32'd0);
        chk("wrmiss_mem_writes", 32'(n_wr - w0), 32'd1);
        chk("wrmiss_mem_addr", wr_addr, 32'h1234_5678);
        chk("wrmiss_mem_wdata", 32'(wr_data), 32'hBB);
        chk("wrmiss_miss_cnt", 32'(miss_cnt), 32'd2);
        chk("wrmiss_rdata_held", 32'(rd), 32'hAA);

        // Timeout: memory never answers
        mem_lat = -1;
        q0 = n_mreq; f0 = n_fill;
        xact(1'b0, 32'h00B0_0000, 8'h00, lat, err, rd);
        chk("tmo_latency", 32'(lat), 32'd6);
        chk("tmo_err_with_done", 32'(err), 32'd1);
        chk("tmo_mem_req_cycles", 32'(n_mreq - q0), 32'd4);
        chk("tmo_no_fill", 32'(n_fill - f0), 32'd0);
        chk("tmo_rdata_held", 32'(rd), 32'hAA);
        chk("tmo_miss_cnt", 32'(miss_cnt), 32'd3);
        chk("tmo_err_one_cycle", 32'(cpu_err), 32'd0);

        mem_lat = 0;
        xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
        chk("post_tmo_latency", 32'(lat), 32'd2);
        chk("post_tmo_rdata", 32'(rd), 32'hAA);
        chk("post_tmo_err", 32'(err), 32'd0);

        // Reset in the middle of a miss fetch
        mem_lat   = -1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h00C0_0040;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        chk("pre_rst_stall", 32'(cpu_stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(cpu_stall), 32'd0);
        chk("async_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("async_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("async_rst_rdata", 32'(cpu_rdata), 32'd0);
        tick();
        tick();
        reset   = 1'b0;
        mem_lat = 0;
        tick();
        xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_rdata", 32'(rd), 32'hAA);
        chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);

        // Saturation of the 2-bit hit counter over five more hits
        for (int k = 2; k <= 6; k++) begin
            xact(1'b0, 32'h00A0_0062, 8'h00, lat, err, rd);
            chk("sat_hit_cnt", 32'(hit_cnt), (k > 3) ? 32'd3 : 32'(k));
        end
        chk("sat_miss_cnt", 32'(miss_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequences the 2-way, 8-set, 32-byte-line byte cache on behalf of a single CPU requester.
- Latches each CPU request and drives one lookup cycle. On a read miss it fetches the line from memory, fills the cache, then replays the lookup.
- All writes go through to memory. Write hits also update the cached byte; write misses do not allocate.
- Sits between the CPU pipeline stall logic, the cache datapath and the memory port. It also keeps hit/miss statistics.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits (32 bytes).
- TIMEOUT, 255, maximum memory wait in cycles; 0 disables the timeout.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = byte write, 0 = byte read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write byte.
- cpu_stall  out  1  high from acceptance until the cycle after cpu_done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read byte; valid with cpu_done, held until the next cpu_done.
- cpu_err  out  1  one-cycle pulse on a timeout or a replay miss.
- cache_addr  out  ADDR_W  address to the cache: latched address when busy, cpu_addr in IDLE.
- cache_hit  in  1  combinational hit for cache_addr.
- cache_data  in  8  combinational byte for cache_addr.
- cache_byte_we  out  1  byte write strobe to the cache (memWrite).
- cache_wbyte  out  8  byte written to the cache.
- cache_fill  out  1  line-fill strobe.
- cache_fill_line  out  LINE_W  fill data.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  line-aligned for reads, byte address for writes.
- mem_wdata  out  8  write byte.
- mem_ready  in  1  transfer completes this cycle; for reads mem_rdata is valid this cycle.
- mem_rdata  in  LINE_W  line read data.
- hit_cnt  out  CNT_W  saturating count of lookup hits.
- miss_cnt  out  CNT_W  saturating count of lookup misses.

Behaviour:
- Reset (asynchronous, immediate):
  - state goes to IDLE.
  - All strobes go to 0, including mem_req, even mid-transfer.
  - cpu_stall goes to 0.
  - cpu_rdata, hit_cnt, miss_cnt and all latches go to 0.
- Latched on acceptance: addr, we, wdata.
- States:
  - IDLE:
    - cpu_req=1 latches the request, sets cpu_stall=1 and goes to LOOKUP.
    - cpu_req in any other state is ignored.
  - LOOKUP (1 cycle): samples cache_hit and updates hit_cnt or miss_cnt.
    - Read hit: cpu_rdata <= cache_data; cpu_done=1 next cycle; go to IDLE. Total latency: done 2 cycles after the request is accepted.
    - Read miss: go to MISS_REQ.
    - Write hit: cache_byte_we=1 and cache_wbyte=wdata this cycle; go to WT_REQ.
    - Write miss: go to WT_REQ.
  - MISS_REQ:
    - Drives mem_req=1, mem_we=0, mem_addr={addr[ADDR_W-1:5], 5'b0}.
    - On mem_ready: latch mem_rdata; go to FILL.
  - FILL (1 cycle): cache_fill=1, cache_fill_line=latched line; go to REPLAY.
  - REPLAY (1 cycle):
    - Hit: cpu_rdata <= cache_data; cpu_done; go to IDLE.
    - Miss: cpu_err and cpu_done pulse together; cpu_rdata is unchanged; go to IDLE.
    - Counters are not updated.
  - WT_REQ:
    - Drives mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
    - On mem_ready: cpu_done; go to IDLE.
- Timeout:
  - The wait counter clears on entry to MISS_REQ or WT_REQ and increments each cycle without mem_ready.
  - When it reaches TIMEOUT (and TIMEOUT≠0), mem_req drops, cpu_err and cpu_done pulse together, and the state goes to IDLE.
  - mem_ready arriving in the expiry cycle wins: the transfer completes normally.
- cpu_done and cpu_err are registered, asserted the cycle after the deciding state. cpu_stall falls together with cpu_done's deassertion.
- Back-to-back: a new cpu_req is accepted in the first IDLE cycle after done.
- Counters: saturate at all-ones (no wrap) and never clear except on reset.
- Address:
  - cache_addr is held stable from LOOKUP through REPLAY.
  - mem_addr and mem_wdata are stable while mem_req=1.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state encoding: IDLE, LOOKUP, MISS_REQ, FILL, REPLAY, WT_REQ;
  - OFFSET_W=5, INDEX_W=3 and the line-alignment mask.
- Sub-module sat_counter (parameter W; ports clk, reset, inc, count) is instantiated twice for hit_cnt and miss_cnt.

Test Plan:
- Read miss then hit:
  - Read 0x00A00062, mem_ready 3 cycles after mem_req.
  - Expect mem_addr=0x00A00060, one cache_fill pulse, then done with rdata = byte 2 of the line; miss_cnt=1.
  - Repeat the read: done 2 cycles after the request, no mem_req, hit_cnt=1.
- Write hit:
  - After the fill, write 0xAA to 0x00A00062.
  - Expect cache_byte_we for 1 cycle and a memory write with addr=0x00A00062, wdata=0xAA.
  - A following read returns 0xAA.
- Write miss:
  - Write 0xBB to 0x12345678.
  - Expect a memory write only: no cache_byte_we, no cache_fill; miss_cnt increments.
- Timeout:
  - TIMEOUT=4, read miss, mem_ready never asserted.
  - Expect mem_req for exactly 4 cycles, then cpu_err and cpu_done together.
  - Next request is accepted normally.
- Reset mid-operation:
  - Assert reset during MISS_REQ.
  - Expect mem_req, cpu_stall and the counters to clear immediately, without waiting for a clock edge.
  - After release, a read request proceeds from LOOKUP.
- Counter saturation:
  - CNT_W=2, five consecutive read hits.
  - Expect hit_cnt to stick at 3.
